// File: rtl/prefetch_queue.sv
// Byte-wide instruction prefetch queue: fetches aligned words from memory and
// presents the next four queued bytes to decode, retiring 1-4 bytes per instruction.
module prefetch_queue #(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic [31:0] ope,
    output logic        ope_valid,
    output logic [31:0] head_eip,
    input  logic [3:0]  num_of_ope,
    input  logic        flush_en,
    input  logic [31:0] flush_addr,
    output logic [3:0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_STALE = 2'd2;

    logic [7:0]    qbuf [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic [29:0]   fptr;
    logic [1:0]    drop;
    logic [1:0]    state;

    logic [7:0]    buf_d [DEPTH];
    logic [PW-1:0] rd_d;
    logic [PW-1:0] wr_d;
    logic [CW-1:0] cnt_d;
    logic [2:0]    ret_n;
    logic [2:0]    wr_n;
    logic [2:0]    need;
    logic [CW-1:0] free_space;
    logic          accept;
    logic          start_req;
    logic [31:0]   ope_d;
    logic [31:0]   head_d;

    // ope is registered from the post-edge buffer image so decode never sees mem_data combinationally
    always_comb begin
        ret_n = 3'd0;
        if (!flush_en && ope_valid && num_of_ope != 4'd0) begin
            ret_n = (num_of_ope > 4'd4) ? 3'd4 : num_of_ope[2:0];
        end

        accept     = (state == ST_WAIT) && mem_ack && !flush_en;
        wr_n       = accept ? (3'd4 - {1'b0, drop}) : 3'd0;
        need       = 3'd4 - {1'b0, drop};
        free_space = CW'(DEPTH) - cnt;
        start_req  = (state == ST_IDLE) && !flush_en && (free_space >= CW'(need));

        for (int i = 0; i < DEPTH; i++) begin
            buf_d[i] = qbuf[i];
        end
        for (int i = 0; i < 4; i++) begin
            if (accept && (2'(i) >= drop)) begin
                buf_d[wr_ptr + PW'(i) - PW'(drop)] = mem_data[8*i +: 8];
            end
        end

        if (flush_en) begin
            rd_d   = '0;
            wr_d   = '0;
            cnt_d  = '0;
            head_d = flush_addr;
        end else begin
            rd_d   = rd_ptr + PW'(ret_n);
            wr_d   = wr_ptr + PW'(wr_n);
            cnt_d  = cnt + CW'(wr_n) - CW'(ret_n);
            head_d = head_eip + 32'(ret_n);
        end

        ope_d = {buf_d[rd_d], buf_d[rd_d + PW'(1)], buf_d[rd_d + PW'(2)], buf_d[rd_d + PW'(3)]};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                qbuf[i] <= 8'h00;
            end
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            ope       <= 32'h0;
            ope_valid <= 1'b0;
            head_eip  <= RESET_ADDR;
            fptr      <= RESET_ADDR[31:2];
            drop      <= RESET_ADDR[1:0];
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= 32'h0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                qbuf[i] <= buf_d[i];
            end
            rd_ptr    <= rd_d;
            wr_ptr    <= wr_d;
            cnt       <= cnt_d;
            ope       <= ope_d;
            ope_valid <= (cnt_d >= CW'(4));
            head_eip  <= head_d;

            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state    <= ST_WAIT;
                        mem_req  <= 1'b1;
                        mem_addr <= {fptr, 2'b00};
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                        if (!flush_en) begin
                            fptr <= fptr + 30'd1;
                            drop <= 2'd0;
                        end
                    end else if (flush_en) begin
                        // the handshake cannot be withdrawn, so wait out the ack and drop it
                        state <= ST_STALE;
                    end
                end
                ST_STALE: begin
                    if (mem_ack) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase

            if (flush_en) begin
                fptr <= flush_addr[31:2];
                drop <= flush_addr[1:0];
            end
        end
    end

    assign count = 4'(cnt);

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: a byte-queue scoreboard is filled on
// accepted acks and drained on retires, and compared with the DUT every cycle.
module tb_prefetch_queue;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic [31:0] ope;
    logic        ope_valid;
    logic [31:0] head_eip;
    logic [3:0]  num_of_ope;
    logic        flush_en;
    logic [31:0] flush_addr;
    logic [3:0]  count;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [64];

    // reference model state
    logic [7:0]  sb [$];
    logic [31:0] m_head;
    logic [29:0] m_fptr;
    logic [1:0]  m_drop;
    logic        m_out;
    logic        m_stale;
    logic [31:0] m_addr;

    prefetch_queue #(.DEPTH(8), .RESET_ADDR(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .ope        (ope),
        .ope_valid  (ope_valid),
        .head_eip   (head_eip),
        .num_of_ope (num_of_ope),
        .flush_en   (flush_en),
        .flush_addr (flush_addr),
        .count      (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ack_ctl: 0 = no ack, 1 = ack when a request is pending, 2 = ack regardless
    task automatic step(input int ack_ctl, input logic [3:0] num, input logic fl,
                        input logic [31:0] fa, input logic rst);
        logic        ack;
        logic [31:0] word;
        int          old_size;
        int          n;
        logic [31:0] exp_ope;
        @(negedge clk);
        reset      = rst;
        num_of_ope = num;
        flush_en   = fl;
        flush_addr = fa;
        ack        = (ack_ctl == 1 && mem_req) || ack_ctl == 2;
        mem_ack    = ack;
        word       = mem[mem_addr[7:2]];
        mem_data   = word;
        @(posedge clk);
        #1;
        if (!rst) begin
            sb.delete();
            m_head  = 32'h0;
            m_fptr  = 30'h0;
            m_drop  = 2'd0;
            m_out   = 1'b0;
            m_stale = 1'b0;
            m_addr  = 32'h0;
        end else begin
            old_size = sb.size();
            if (!fl && num != 4'd0 && old_size >= 4) begin
                n = (num > 4'd4) ? 4 : int'(num);
                repeat (n) void'(sb.pop_front());
                m_head = m_head + 32'(n);
            end
            if (m_out) begin
                if (ack) begin
                    if (!m_stale && !fl) begin
                        for (int i = int'(m_drop); i < 4; i++) sb.push_back(word[8*i +: 8]);
                        m_fptr = m_fptr + 30'd1;
                        m_drop = 2'd0;
                    end
                    m_out   = 1'b0;
                    m_stale = 1'b0;
                end else if (fl) begin
                    m_stale = 1'b1;
                end
            end else if (!fl && (8 - old_size >= 4 - int'(m_drop))) begin
                m_out  = 1'b1;
                m_addr = {m_fptr, 2'b00};
            end
            if (fl) begin
                sb.delete();
                m_head = fa;
                m_fptr = fa[31:2];
                m_drop = fa[1:0];
            end
        end
        mem_ack = 1'b0;

        checks++;
        if (count !== 4'(sb.size())) begin
            errors++;
            $display("[TB] FAIL sb_count: got %0d expected %0d", count, sb.size());
        end
        checks++;
        if (ope_valid !== (sb.size() >= 4)) begin
            errors++;
            $display("[TB] FAIL sb_ope_valid: got %0b expected %0b", ope_valid, sb.size() >= 4);
        end
        checks++;
        if (head_eip !== m_head) begin
            errors++;
            $display("[TB] FAIL sb_head_eip: got %h expected %h", head_eip, m_head);
        end
        checks++;
        if (mem_req !== m_out) begin
            errors++;
            $display("[TB] FAIL sb_mem_req: got %0b expected %0b", mem_req, m_out);
        end
        checks++;
        if (mem_addr !== m_addr) begin
            errors++;
            $display("[TB] FAIL sb_mem_addr: got %h expected %h", mem_addr, m_addr);
        end
        if (sb.size() >= 4) begin
            exp_ope = {sb[0], sb[1], sb[2], sb[3]};
            checks++;
            if (ope !== exp_ope) begin
                errors++;
                $display("[TB] FAIL sb_ope: got %h expected %h", ope, exp_ope);
            end
        end
    endtask

    task automatic test_reset();
        step(0, 4'd0, 1'b0, 32'h0, 1'b0);
        step(0, 4'd0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (ope !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_ope: got %h expected 00000000", ope);
        end
        step(1, 4'd0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL first_req: got req=%0b addr=%h expected req=1 addr=00000000", mem_req, mem_addr);
        end
        step(1, 4'd0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (count !== 4'd4 || ope !== 32'h5589_E583 || ope_valid !== 1'b1 || head_eip !== 32'h0) begin
            errors++;
            $display("[TB] FAIL first_word: got count=%0d ope=%h valid=%0b head=%h expected 4 5589e583 1 0",
                     count, ope, ope_valid, head_eip);
        end
    endtask

    task automatic test_retire();
        step(1, 4'd0, 1'b0, 32'h0, 1'b1);
        step(1, 4'd0, 1'b0, 32'h0, 1'b1);
        step(1, 4'd1, 1'b0, 32'h0, 1'b1);
        checks++;
        if (ope !== 32'h89E5_83EC || head_eip !== 32'h1) begin
            errors++;
            $display("[TB] FAIL retire1: got ope=%h head=%h expected 89e583ec 1", ope, head_eip);
        end
        step(1, 4'd2, 1'b0, 32'h0, 1'b1);
        checks++;
        if (ope !== 32'h83EC_0400 || head_eip !== 32'h3) begin
            errors++;
            $display("[TB] FAIL retire2: got ope=%h head=%h expected 83ec0400 3", ope, head_eip);
        end
    endtask

    task automatic test_full();
        step(1, 4'd1, 1'b0, 32'h0, 1'b1);
        repeat (8) step(1, 4'd0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (count !== 4'd8 || mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full: got count=%0d req=%0b expected 8 0", count, mem_req);
        end
    endtask

    task automatic test_flush_stale();
        step(0, 4'd0, 1'b0, 32'h0, 1'b0);
        step(0, 4'd0, 1'b0, 32'h0, 1'b0);
        step(1, 4'd0, 1'b0, 32'h0, 1'b1);
        step(1, 4'd0, 1'b0, 32'h0, 1'b1);
        step(0, 4'd0, 1'b0, 32'h0, 1'b1);
        step(0, 4'd0, 1'b1, 32'h6, 1'b1);
        checks++;
        if (mem_req !== 1'b1 || count !== 4'd0 || head_eip !== 32'h6) begin
            errors++;
            $display("[TB] FAIL flush_hold: got req=%0b count=%0d head=%h expected 1 0 6", mem_req, count, head_eip);
        end
        step(1, 4'd0, 1'b0, 32'h0, 1'b1);
        step(1, 4'd0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (mem_addr !== 32'h4) begin
            errors++;
            $display("[TB] FAIL redirect_addr: got %h expected 00000004", mem_addr);
        end
        step(1, 4'd0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (count !== 4'd2 || ope_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop2: got count=%0d valid=%0b expected 2 0", count, ope_valid);
        end
        step(1, 4'd0, 1'b0, 32'h0, 1'b1);
        step(1, 4'd0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (count !== 4'd6 || ope_valid !== 1'b1 || head_eip !== 32'h6) begin
            errors++;
            $display("[TB] FAIL after_redirect: got count=%0d valid=%0b head=%h expected 6 1 6",
                     count, ope_valid, head_eip);
        end
    endtask

    task automatic test_ack_and_retire();
        step(0, 4'd2, 1'b0, 32'h0, 1'b1);
        step(0, 4'd0, 1'b0, 32'h0, 1'b1);
        step(1, 4'd4, 1'b0, 32'h0, 1'b1);
        checks++;
        if (count !== 4'd4 || ope !== 32'hF0E1_D2C3 || head_eip !== 32'hC) begin
            errors++;
            $display("[TB] FAIL ack_retire: got count=%0d ope=%h head=%h expected 4 f0e1d2c3 c",
                     count, ope, head_eip);
        end
    endtask

    task automatic test_reset_in_wait();
        step(0, 4'd0, 1'b0, 32'h0, 1'b1);
        step(0, 4'd0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || ope !== 32'h0 || ope_valid !== 1'b0 ||
            head_eip !== 32'h0 || count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_wait: got req=%0b addr=%h ope=%h valid=%0b head=%h count=%0d expected all zero",
                     mem_req, mem_addr, ope, ope_valid, head_eip, count);
        end
        step(2, 4'd0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (count !== 4'd0 || mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL late_ack: got count=%0d req=%0b addr=%h expected 0 1 00000000",
                     count, mem_req, mem_addr);
        end
    endtask

    task automatic test_flush_with_ack();
        step(2, 4'd0, 1'b1, 32'h21, 1'b1);
        step(1, 4'd0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin
            errors++;
            $display("[TB] FAIL flush_ack_redirect: got req=%0b addr=%h expected 1 00000020", mem_req, mem_addr);
        end
        step(1, 4'd0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (count !== 4'd3 || head_eip !== 32'h21) begin
            errors++;
            $display("[TB] FAIL drop1: got count=%0d head=%h expected 3 00000021", count, head_eip);
        end
    endtask

    task automatic test_back_to_back();
        repeat (6) step(1, 4'd0, 1'b0, 32'h0, 1'b1);
        repeat (20) step(1, 4'd1, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 3) == 0) ? 0 : 1, 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 24) == 0), 32'($urandom_range(0, 255)), 1'b1);
        end
    endtask

    initial begin
        reset      = 1'b0;
        mem_ack    = 1'b0;
        mem_data   = 32'h0;
        num_of_ope = 4'd0;
        flush_en   = 1'b0;
        flush_addr = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h83E5_8955;
        mem[1] = 32'h0000_04EC;
        mem[3] = 32'hC3D2_E1F0;

        test_reset();
        test_retire();
        test_full();
        test_flush_stale();
        test_ack_and_retire();
        test_reset_in_wait();
        test_flush_with_ack();
        test_back_to_back();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prefetch_queue.md
# prefetch_queue

Byte-wide instruction prefetch queue between instruction memory and `decode`. It fetches aligned 32-bit words ahead of execution and keeps up to DEPTH instruction bytes. It presents the next four bytes as `ope` in the 32-bit layout `decode` consumes. It retires 1–4 bytes per instruction according to `num_of_ope`, and is flushed and redirected when `eip` is loaded by a jump or call.

## Interface
Parameters:
- DEPTH, 8, queue capacity in bytes; power of two, ≥ 8.
- RESET_ADDR, 32'h0000_0000, byte address fetched after reset.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low; 0 sampled at a rising edge resets the block.
- mem_req  out  1  word read request; held high until `mem_ack`.
- mem_addr  out  32  word-aligned read address (bits [1:0] = 0); stable while `mem_req`=1.
- mem_ack  in  1  read complete; `mem_data` valid in this cycle.
- mem_data  in  32  read word, little-endian: [7:0] = byte at `mem_addr`.
- ope  out  32  next four queued bytes; oldest byte in [31:24], fourth byte in [7:0].
- ope_valid  out  1  queue holds ≥ 4 bytes.
- head_eip  out  32  byte address of the oldest queued byte (`ope[31:24]`).
- num_of_ope  in  4  bytes retired by the current instruction; values 1–4 are valid, 0 means no retire.
- flush_en  in  1  discard the queue and refetch from `flush_addr`.
- flush_addr  in  32  new byte address; may be unaligned.
- count  out  4  bytes currently queued (0..DEPTH).

## Operation
- Storage: circular byte buffer of DEPTH entries with read and write pointers, plus a byte count. `ope` is driven from registers and reflects the state at the last edge.
- Fetch pointer `fptr` (word address) and `drop` (0–3 leading bytes to discard):
  - Reset: `fptr` = RESET_ADDR[31:2], `drop` = RESET_ADDR[1:0].
  - Flush: `fptr` = flush_addr[31:2], `drop` = flush_addr[1:0].
- Request FSM, states IDLE / WAIT / STALE:
  - IDLE → WAIT when `DEPTH - count ≥ 4 - drop`. Drive `mem_req`=1 and `mem_addr = {fptr, 2'b00}`.
  - WAIT on `mem_ack`: write bytes `drop..3` of `mem_data` in address order, set `fptr += 1` and `drop` = 0, then go to IDLE.
  - WAIT on `flush_en` without `mem_ack`: go to STALE. `mem_req` stays high until the ack, because the memory handshake cannot be withdrawn.
  - STALE on `mem_ack`: discard the data and go to IDLE.
- Retire: when `num_of_ope` is 1–4 and `ope_valid`=1, advance the read pointer and `head_eip` by `num_of_ope`.
  - `num_of_ope` > 4 is clamped to 4.
  - A retire while `ope_valid`=0 is ignored.
- Flush: empties the queue (count = 0) and sets `head_eip` = `flush_addr`.
  - Flush takes priority over a retire and over an ack in the same cycle; both are dropped.
  - Flush with `mem_ack` in the same cycle: the ack completes the old request and is discarded. The FSM goes to IDLE, not STALE.
- Same-cycle ack and retire: count_next = count + written − retired. Free space for the request decision uses the registered `count` only.
- Wrap-around: pointers are modulo DEPTH. `fptr` and `head_eip` wrap modulo 2^32 silently.
- Full: no request is issued while free space < 4 − `drop`. No request is issued in the same cycle as `flush_en`.
- Reset mid-operation: all state is cleared regardless of an outstanding request. An ack arriving after reset with FSM in IDLE is ignored.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `ope`=0, `ope_valid`=0, `head_eip`=RESET_ADDR, `count`=0, FSM = IDLE.
- `mem_req` rises on the first edge after reset is released (cycle 1), then on the edge after entering IDLE with enough free space.
- Ack at edge N: the bytes appear in `count`, `ope` and `ope_valid` after edge N. There is no combinational path from `mem_data` to `ope`.
- Retire at edge N: `ope` and `head_eip` are updated after edge N. Back-to-back retires are supported every cycle while `ope_valid`=1.
- Redirect latency: a flush at edge N allows `mem_req` for the new address from edge N+1 (IDLE), or one cycle after the stale ack.
- Throughput: one word per two cycles minimum (request cycle, then ack cycle).

## Test plan
- Reset low for 2 cycles, then memory acks next cycle with 32'h83E5_8955 at address 0 → `mem_addr`=0; after the ack, `count`=4, `ope`=32'h5589_E583, `ope_valid`=1, `head_eip`=0.
- With `ope`=32'h5589_E583 and the next word 32'h0000_04EC, retire 1 → `ope`=32'h89E5_83EC, `head_eip`=1. Then retire 2 → `ope`=32'h83EC_0400, `head_eip`=3.
- Memory always acks and nothing retires → `count` saturates at 8, `mem_req` stays 0 while `count` > 4, no byte is overwritten.
- Flush to 32'h0000_0006 while a request to address 4 is outstanding → the stale ack is discarded. The next request is to address 4 with `drop`=2, giving `count`=2 and `ope_valid`=0. After the word at address 8, `count`=6, `ope_valid`=1 and `head_eip`=6.
- Ack adds 4 bytes while retiring 4 with `count`=4 → `count` stays 4, `ope` equals the new word byte-swapped, `head_eip` += 4.
- Reset asserted during WAIT → after that edge all outputs are at reset values. An ack one cycle later leaves `count`=0, and a new request goes to RESET_ADDR.
